// File: rtl/moving_average_sel.sv
// moving_average_sel: runtime-selectable moving-average filter.
// Averages the last 2^p accepted samples, p in 0..MAX_POWER, using one ring
// buffer and one running sum. Missing history during fill counts as zero.
module moving_average_sel #(
    parameter int DATA_IN_LEN = 10,
    parameter int MAX_POWER   = 4,
    parameter int ROUND       = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_IN_LEN-1:0] data_in,
    input  logic                   strobe_in,
    input  logic [2:0]             power_sel,
    output logic [DATA_IN_LEN-1:0] data_out,
    output logic                   strobe_out,
    output logic                   full
);

    localparam int DEPTH = 1 << MAX_POWER;
    localparam int SW    = DATA_IN_LEN + MAX_POWER;

    logic [DATA_IN_LEN-1:0] ring_buf [DEPTH];
    logic [2:0]             cur_p;
    logic [MAX_POWER-1:0]   wr_ptr;
    logic [MAX_POWER:0]     cnt;
    logic [SW-1:0]          sum;

    logic [2:0]             new_p;
    logic                   reconfig;
    logic [2:0]             eff_p;
    logic [MAX_POWER:0]     n_eff;
    logic                   run_mode;
    logic [MAX_POWER-1:0]   rd_ptr;
    logic [DATA_IN_LEN-1:0] leaving;
    logic [SW-1:0]          sum_next;
    logic [MAX_POWER:0]     cnt_next;
    logic [SW-1:0]          rnd;
    logic [SW-1:0]          avg_wide;

    // Requested exponents beyond the ring depth collapse onto the largest window.
    function automatic logic [2:0] clamp_p(input logic [2:0] p);
        return (int'(p) > MAX_POWER) ? 3'(MAX_POWER) : p;
    endfunction

    // Next sum, count and result for a sample accepted this cycle.
    always_comb begin
        // NOTE: every output of this block gets a value on every path (defaults
        // first), otherwise synthesis infers a latch to hold the old value.
        new_p    = clamp_p(power_sel);
        reconfig = (new_p != cur_p);
        eff_p    = reconfig ? new_p : cur_p;
        n_eff    = {{MAX_POWER{1'b0}}, 1'b1} << eff_p;
        // A reconfiguring sample opens a fresh window, so it never evicts anything.
        run_mode = !reconfig && (cnt == n_eff);
        // Truncation to MAX_POWER bits makes the read address wrap modulo depth;
        // a full-depth window reads back the slot about to be overwritten.
        rd_ptr   = wr_ptr - n_eff[MAX_POWER-1:0];
        leaving  = '0;
        if (run_mode) begin
            leaving = ring_buf[rd_ptr];
        end
        sum_next = (reconfig ? '0 : sum) + SW'(data_in) - SW'(leaving);
        cnt_next = reconfig ? {{MAX_POWER{1'b0}}, 1'b1}
                            : (run_mode ? cnt : cnt + 1'b1);
        rnd = '0;
        if (ROUND != 0 && eff_p != 3'd0) begin
            rnd = {{(SW-1){1'b0}}, 1'b1} << (eff_p - 3'd1);
        end
        // The sum never exceeds (2^DATA_IN_LEN-1)*2^p, so adding half an LSB
        // and shifting cannot exceed the output range.
        avg_wide = (sum_next + rnd) >> eff_p;
    end

    // Sample storage; contents outside the active window are never observed.
    always_ff @(posedge clk) begin
        // NOTE: the ring is deliberately not reset: FILL mode masks stale
        // entries, and leaving it reset-free lets it map onto plain RAM.
        if (strobe_in) begin
            ring_buf[wr_ptr] <= data_in;
        end
    end

    // Filter state and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            cur_p      <= clamp_p(power_sel);
            wr_ptr     <= '0;
            cnt        <= '0;
            sum        <= '0;
            data_out   <= '0;
            strobe_out <= 1'b0;
            full       <= 1'b0;
        end else begin
            strobe_out <= 1'b0;
            if (reconfig) begin
                cur_p <= new_p;
                sum   <= '0;
                cnt   <= '0;
                full  <= 1'b0;
            end
            if (strobe_in) begin
                wr_ptr     <= wr_ptr + 1'b1;
                sum        <= sum_next;
                cnt        <= cnt_next;
                data_out   <= avg_wide[DATA_IN_LEN-1:0];
                strobe_out <= 1'b1;
                full       <= (cnt_next == n_eff);
            end
        end
    end

endmodule

// File: tb/tb_moving_average_sel.sv
// Testbench for moving_average_sel: a truncating and a rounding instance share
// stimulus and are compared against a window-of-samples reference model.
module tb_moving_average_sel;

    localparam int MAXP = 4;

    logic       clk;
    logic       reset;
    logic [9:0] data_in;
    logic       strobe_in;
    logic [2:0] power_sel;
    logic [9:0] d0, d1;
    logic       s0, s1, f0, f1;

    int total = 0;
    int bad   = 0;

    // Reference model: the samples currently inside the window.
    int         hist[$];
    int         m_p;
    logic [9:0] e_out0, e_out1;
    logic       e_strobe, e_full;
    int         n_in, n_out;

    moving_average_sel #(.DATA_IN_LEN(10), .MAX_POWER(MAXP), .ROUND(0)) u_trunc (
        .clk(clk), .reset(reset), .data_in(data_in), .strobe_in(strobe_in),
        .power_sel(power_sel), .data_out(d0), .strobe_out(s0), .full(f0));

    moving_average_sel #(.DATA_IN_LEN(10), .MAX_POWER(MAXP), .ROUND(1)) u_round (
        .clk(clk), .reset(reset), .data_in(data_in), .strobe_in(strobe_in),
        .power_sel(power_sel), .data_out(d1), .strobe_out(s1), .full(f1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle (inputs set at the falling edge), then update the model
    // and leave the bench at the next falling edge where outputs are stable.
    task automatic cycle(input bit rst, input bit s, input logic [9:0] d, input logic [2:0] ps);
        int cp, sm, n;
        reset = rst; strobe_in = s; data_in = d; power_sel = ps;
        @(negedge clk);
        cp = (int'(ps) > MAXP) ? MAXP : int'(ps);
        if (rst) begin
            hist.delete();
            m_p = cp; e_out0 = '0; e_out1 = '0; e_strobe = 1'b0;
        end else begin
            if (cp != m_p) begin
                hist.delete();
                m_p = cp;
            end
            e_strobe = s;
            if (s) begin
                n_in++;
                n = 1 << m_p;
                hist.push_back(int'(d));
                while (hist.size() > n) void'(hist.pop_front());
                sm = 0;
                foreach (hist[k]) sm += hist[k];
                e_out0 = 10'(sm >> m_p);
                e_out1 = (m_p > 0) ? 10'((sm + (n / 2)) >> m_p) : 10'(sm);
            end
        end
        e_full = (hist.size() == (1 << m_p));
        if (s0) n_out++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 10'd1023, 3'd0);
            total++;
            if (d0 !== 10'd0 || s0 !== 1'b0 || f0 !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold i=%0d got d=%0d s=%0b f=%0b want 0/0/0", i, d0, s0, f0);
            end
        end
        cycle(0, 1, 10'd5, 3'd0);
        total++;
        if (d0 !== 10'd5 || s0 !== 1'b1) begin
            bad++;
            $display("FAIL reset_first got d=%0d s=%0b want d=5 s=1", d0, s0);
        end
        total++;
        if (f0 !== 1'b1) begin
            bad++;
            $display("FAIL reset_first_full got=%0b want=1", f0);
        end
    endtask

    task automatic test_fill_run();
        logic [9:0] want[5];
        logic       wfull[5];
        want  = '{10'd1, 10'd3, 10'd6, 10'd10, 10'd14};
        wfull = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        cycle(1, 0, 10'd0, 3'd2);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 10'(4 * (i + 1)), 3'd2);
            total++;
            if (d0 !== want[i] || s0 !== 1'b1 || f0 !== wfull[i]) begin
                bad++;
                $display("FAIL fill_run i=%0d got d=%0d s=%0b f=%0b want d=%0d s=1 f=%0b",
                         i, d0, s0, f0, want[i], wfull[i]);
            end
        end
    endtask

    task automatic test_rounding();
        logic [9:0] stim[3];
        logic [9:0] w_tr[3];
        logic [9:0] w_rd[3];
        stim = '{10'd1, 10'd2, 10'd2};
        w_tr = '{10'd0, 10'd1, 10'd2};
        w_rd = '{10'd1, 10'd2, 10'd2};
        cycle(1, 0, 10'd0, 3'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, stim[i], 3'd1);
            total++;
            if (d0 !== w_tr[i] || d1 !== w_rd[i]) begin
                bad++;
                $display("FAIL rounding i=%0d got trunc=%0d round=%0d want trunc=%0d round=%0d",
                         i, d0, d1, w_tr[i], w_rd[i]);
            end
        end
    endtask

    task automatic test_extremes();
        cycle(1, 0, 10'd0, 3'd4);
        for (int i = 0; i < 40; i++) begin
            cycle(0, 1, 10'd1023, 3'd4);
            total++;
            if (d0 !== e_out0 || d1 !== e_out1 || f0 !== e_full) begin
                bad++;
                $display("FAIL extreme_fill i=%0d got d0=%0d d1=%0d f=%0b want d0=%0d d1=%0d f=%0b",
                         i, d0, d1, f0, e_out0, e_out1, e_full);
            end
            if (i >= 15) begin
                total++;
                if (d0 !== 10'd1023 || d1 !== 10'd1023 || f0 !== 1'b1) begin
                    bad++;
                    $display("FAIL extreme_max i=%0d got d0=%0d d1=%0d f=%0b want 1023/1023/1",
                             i, d0, d1, f0);
                end
            end
        end
        for (int i = 0; i < 16; i++) begin
            cycle(0, 1, 10'd0, 3'd4);
            total++;
            if (d0 !== e_out0 || d1 !== e_out1) begin
                bad++;
                $display("FAIL extreme_drain i=%0d got d0=%0d d1=%0d want d0=%0d d1=%0d",
                         i, d0, d1, e_out0, e_out1);
            end
        end
        total++;
        if (d0 !== 10'd0 || d1 !== 10'd0) begin
            bad++;
            $display("FAIL extreme_zero got d0=%0d d1=%0d want 0/0", d0, d1);
        end
    endtask

    task automatic test_reconfig();
        logic [9:0] r;
        cycle(1, 0, 10'd0, 3'd2);
        for (int i = 0; i < 4; i++) cycle(0, 1, 10'd8, 3'd2);
        total++;
        if (d0 !== 10'd8 || f0 !== 1'b1) begin
            bad++;
            $display("FAIL reconf_setup got d=%0d f=%0b want d=8 f=1", d0, f0);
        end
        cycle(0, 1, 10'd6, 3'd1);
        total++;
        if (d0 !== 10'd3 || f0 !== 1'b0 || s0 !== 1'b1) begin
            bad++;
            $display("FAIL reconf_switch got d=%0d f=%0b s=%0b want d=3 f=0 s=1", d0, f0, s0);
        end
        cycle(0, 0, 10'd0, 3'd1);
        total++;
        if (s0 !== 1'b0 || d0 !== 10'd3) begin
            bad++;
            $display("FAIL reconf_single got s=%0b d=%0d want s=0 d=3", s0, d0);
        end
        cycle(0, 1, 10'd6, 3'd1);
        total++;
        if (d0 !== 10'd6 || f0 !== 1'b1) begin
            bad++;
            $display("FAIL reconf_second got d=%0d f=%0b want d=6 f=1", d0, f0);
        end
        // power_sel=7 must act as the 16-deep window.
        cycle(0, 0, 10'd0, 3'd7);
        total++;
        if (s0 !== 1'b0 || f0 !== 1'b0) begin
            bad++;
            $display("FAIL clamp_idle got s=%0b f=%0b want s=0 f=0", s0, f0);
        end
        for (int i = 0; i < 18; i++) begin
            r = 10'($urandom_range(0, 1023));
            cycle(0, 1, r, 3'd7);
            total++;
            if (d0 !== e_out0 || d1 !== e_out1 || f0 !== (i >= 15)) begin
                bad++;
                $display("FAIL clamp i=%0d got d0=%0d d1=%0d f=%0b want d0=%0d d1=%0d f=%0b",
                         i, d0, d1, f0, e_out0, e_out1, i >= 15);
            end
        end
    endtask

    task automatic test_gaps();
        logic [9:0] held;
        int gap;
        cycle(1, 0, 10'd0, 3'd3);
        n_in = 0; n_out = 0;
        for (int i = 0; i < 60; i++) begin
            cycle(0, 1, 10'($urandom_range(0, 1023)), 3'd3);
            total++;
            if (d0 !== e_out0 || d1 !== e_out1 || s0 !== 1'b1 || f0 !== e_full) begin
                bad++;
                $display("FAIL gaps_out i=%0d got d0=%0d d1=%0d s=%0b f=%0b want d0=%0d d1=%0d s=1 f=%0b",
                         i, d0, d1, s0, f0, e_out0, e_out1, e_full);
            end
            held = d0;
            gap = int'($urandom_range(0, 5));
            for (int g = 0; g < gap; g++) begin
                cycle(0, 0, 10'($urandom_range(0, 1023)), 3'd3);
                total++;
                if (d0 !== held || s0 !== 1'b0) begin
                    bad++;
                    $display("FAIL gaps_hold i=%0d g=%0d got d=%0d s=%0b want d=%0d s=0",
                             i, g, d0, s0, held);
                end
            end
        end
        total++;
        if (n_out != n_in) begin
            bad++;
            $display("FAIL gaps_count got strobes_out=%0d want %0d", n_out, n_in);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ps;
        bit rst, s;
        ps = 3'd2;
        cycle(1, 0, 10'd0, ps);
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 14) == 0) ps = 3'($urandom_range(0, 7));
            s = ($urandom_range(0, 9) < 7);
            cycle(rst, s, 10'($urandom_range(0, 1023)), ps);
            total++;
            if (d0 !== e_out0 || d1 !== e_out1 || s0 !== e_strobe || f0 !== e_full
                || s1 !== e_strobe || f1 !== e_full) begin
                bad++;
                $display("FAIL random i=%0d got d0=%0d d1=%0d s=%0b f=%0b want d0=%0d d1=%0d s=%0b f=%0b",
                         i, d0, d1, s0, f0, e_out0, e_out1, e_strobe, e_full);
            end
        end
    endtask

    initial begin
        reset = 1'b1; strobe_in = 1'b0; data_in = '0; power_sel = '0;
        m_p = 0; n_in = 0; n_out = 0;
        e_out0 = '0; e_out1 = '0; e_strobe = 1'b0; e_full = 1'b0;
        test_reset();
        test_fill_run();
        test_rounding();
        test_extremes();
        test_reconfig();
        test_gaps();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/moving_average_sel.md
# moving_average_sel

Runtime-configurable moving-average filter. It averages the last 2^p strobed samples, where p is chosen at run time from 0 to MAX_POWER. It replaces a bank of fixed-length filters plus an output mux with one ring buffer and one running sum. The block sits between the strobed input path and the output pins, and optionally rounds instead of truncating.

## Interface
- DATA_IN_LEN, 10: sample width in bits, unsigned.
- MAX_POWER, 4: log2 of the largest window. Ring depth is 2^MAX_POWER. Legal range 1..7.
- ROUND, 0: 0 truncates the quotient; 1 rounds half-up.

Ports:
- clk  in  1  clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  DATA_IN_LEN  sample, valid when strobe_in=1.
- strobe_in  in  1  single-cycle sample-valid pulse; may be high on consecutive cycles.
- power_sel  in  3  requested window exponent p. Values above MAX_POWER clamp to MAX_POWER.
- data_out  out  DATA_IN_LEN  filtered result, registered.
- strobe_out  out  1  result-valid pulse, one per accepted sample.
- full  out  1  high once the current window holds 2^p real samples.

## Operation
- State:
  - cur_p: active exponent.
  - buf: 2^MAX_POWER × DATA_IN_LEN ring.
  - wr_ptr: MAX_POWER bits, wraps modulo depth.
  - cnt: MAX_POWER+1 bits, saturates at N=2^cur_p.
  - sum: DATA_IN_LEN+MAX_POWER bits, cannot overflow.
- Two modes:
  - FILL (cnt<N): leaving sample is treated as 0, so missing history reads as zeros.
  - RUN (cnt==N): leaving sample is buf[(wr_ptr−N) mod depth], read before the same-cycle write.
- Accepted sample (strobe_in=1, no reconfig):
  - buf[wr_ptr]<=data_in; wr_ptr<=wr_ptr+1.
  - sum<=sum+data_in−leaving.
  - cnt<=min(cnt+1,N).
- Result:
  - data_out <= (sum_next + (ROUND && cur_p>0 ? 2^(cur_p−1) : 0)) >> cur_p.
  - cur_p=0 is a pass-through.
  - The result never exceeds 2^DATA_IN_LEN−1, so no saturation logic is needed.
- Reconfiguration:
  - Trigger: clamp(power_sel) ≠ cur_p in any cycle.
  - Action: cur_p<=clamp(power_sel), sum<=0, cnt<=0, full<=0. wr_ptr is kept and buf is not cleared.
  - If strobe_in is high in the same cycle, the sample is the first of the new window: sum<=data_in, cnt<=1, buf write happens. The output uses the new p.
- No strobe: sum, cnt, buf and data_out hold; strobe_out=0.
- Reset:
  - data_out=0, strobe_out=0, full=0, sum=0, cnt=0, wr_ptr=0.
  - cur_p<=clamp(power_sel).
  - buf contents are don't-care, because FILL masks them.
  - Reset mid-stream discards all history; the first post-reset output behaves like a fresh fill.

## Timing
- Latency: strobe_in at edge t gives data_out and strobe_out valid after edge t+1. One-cycle latency, full throughput of one sample per cycle.
- strobe_out is high for exactly one cycle per accepted sample.
- data_out holds between strobes.
- full rises in the same cycle as the strobe_out of the N-th sample after a reset or reconfiguration. It stays high until the next reset or reconfiguration.
- power_sel is sampled every cycle. Callers change it only when filter history may be discarded.
- Reconfiguration does not create an extra strobe_out.
- Wrap-around: wr_ptr rolls from depth−1 to 0. The leaving-sample address is computed modulo depth, so averages across the wrap stay exact.

## Test plan
- Reset: hold reset for 3 cycles while strobing 1023 → data_out=0, strobe_out=0, full=0 throughout; the first post-reset strobe of 5 with p=0 → data_out=5 one cycle later.
- Fill and run, p=2, ROUND=0: strobe 4, 8, 12, 16, 20 back-to-back → outputs 1, 3, 6, 10, 14 on consecutive cycles; full rises with the output 10.
- Rounding, ROUND=1, p=1: strobe 1, 2, 2 → outputs 1, 2, 2. With ROUND=0 the same stimulus → 0, 1, 2.
- Extremes and wrap, p=4: 40 strobes of 1023 → the 16th and all later outputs are exactly 1023 with full=1, no overflow across the wr_ptr wrap; then 16 zeros → output steps down to exactly 0.
- Reconfiguration with simultaneous strobe:
  - Setup: p=2, window full of 8s (output 8).
  - Stimulus: in one cycle set power_sel=1 and strobe 6.
  - Response: output 3, full=0, exactly one strobe_out.
  - Next: strobe 6 → output 6, full=1.
  - Clamp check: power_sel=7 → behaves as p=4.
- Gaps: strobes separated by 0–5 idle cycles, randomly, p=3 → outputs match a reference model. strobe_out count equals strobe_in count; data_out is stable during gaps.
